trigger_sequencer: RTL and testbench

Multi-stage, parametrised trigger engine; successor to the single-condition per-channel trigger.
- Sits between the sample front end and the capture controller.
- Evaluates up to NUM_STAGES ordered conditions, each combining level, edge and don't-care per channel, with a per-stage occurrence count.
- Issues a one-cycle run pulse to the controller when the last enabled stage completes.

---
 rtl/trigger_pkg.sv | 46 ++++
 rtl/trigger_sequencer_if.sv | 30 +++
 rtl/trigger_stage_match.sv | 51 +++++
 rtl/trigger_sequencer.sv | 170 +++++++++++++++++
 tb/tb_trigger_sequencer.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trigger_pkg.sv
// Shared types and helpers for the multi-stage trigger sequencer.
// Optional TRIG_DELAY_EN adds a post-trigger delay state.
package trigger_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DELAY,
    FIRED,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    C_DC,
    C_LEVEL,
    C_RISE,
    C_FALL,
    C_ANY
  } cond_e;

  function automatic int STAGE_IDX_W(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int COUNT_W(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic cond_e bit_cond(
    input logic m,
    input logic r,
    input logic f
  );
    cond_e c;
    c = C_DC;
    unique case (1'b1)
      r && f:        c = C_ANY;
      r && !f:       c = C_RISE;
      !r && f:       c = C_FALL;
      m && !r && !f: c = C_LEVEL;
      default:       c = C_DC;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/trigger_sequencer_if.sv
// Sample/control bundle between front end, sequencer and controller.
// Used by the default and TRIG_DELAY_EN builds alike.
interface trigger_sequencer_if
  import trigger_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8,
  parameter int NUM_STAGES   = 4
) ();

  localparam int SI = STAGE_IDX_W(NUM_STAGES);

  logic                    valid;
  logic                    arm;
  logic                    abort;
  logic [SAMPLE_WIDTH-1:0] dataIn;
  logic                    run;
  logic                    armed;
  logic [SI-1:0]           stage;

  modport master (
    output valid, arm, abort, dataIn,
    input  run, armed, stage
  );

  modport slave (
    input  valid, arm, abort, dataIn,
    output run, armed, stage
  );

endinterface

// File: rtl/trigger_stage_match.sv
// One-stage sample comparator with its own previous-sample history.
// Shared by all stages; config slices are muxed in by the sequencer.
module trigger_stage_match
  import trigger_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    valid,
  input  logic                    clear,
  input  logic [SAMPLE_WIDTH-1:0] dataIn,
  input  logic [SAMPLE_WIDTH-1:0] mask,
  input  logic [SAMPLE_WIDTH-1:0] value,
  input  logic [SAMPLE_WIDTH-1:0] rise,
  input  logic [SAMPLE_WIDTH-1:0] fall,
  output logic                    match
);

  logic [SAMPLE_WIDTH-1:0] prev_q;
  logic                    hist_q;
  logic [SAMPLE_WIDTH-1:0] ok;

  // clear wins so the first armed sample only seeds history
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      hist_q <= 1'b0;
    end else if (clear) begin
      hist_q <= 1'b0;
    end else if (valid) begin
      prev_q <= dataIn;
      hist_q <= 1'b1;
    end
  end

  always_comb begin
    ok = '0;
    for (int i = 0; i < SAMPLE_WIDTH; i++) begin
      unique case (bit_cond(mask[i], rise[i], fall[i]))
        C_ANY:   ok[i] = hist_q && (prev_q[i] != dataIn[i]);
        C_RISE:  ok[i] = hist_q && !prev_q[i] && dataIn[i];
        C_FALL:  ok[i] = hist_q && prev_q[i] && !dataIn[i];
        C_LEVEL: ok[i] = (dataIn[i] == value[i]);
        default: ok[i] = 1'b1;
      endcase
    end
    match = valid && (&ok);
  end

endmodule

// File: rtl/trigger_sequencer.sv
// Ordered multi-stage trigger engine issuing a one-cycle run pulse.
// Define TRIG_DELAY_EN to add delayCount and a DELAY state before FIRED.
module trigger_sequencer
  import trigger_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8,
  parameter int NUM_STAGES   = 4,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  trigger_sequencer_if.slave                bus,
  input  logic [NUM_STAGES*SAMPLE_WIDTH-1:0] stageMask,
  input  logic [NUM_STAGES*SAMPLE_WIDTH-1:0] stageValue,
  input  logic [NUM_STAGES*SAMPLE_WIDTH-1:0] stageRise,
  input  logic [NUM_STAGES*SAMPLE_WIDTH-1:0] stageFall,
  input  logic [NUM_STAGES*COUNT_WIDTH-1:0]  stageCount,
  input  logic [COUNT_W(NUM_STAGES)-1:0]     numStages
`ifdef TRIG_DELAY_EN
  ,
  input  logic [COUNT_WIDTH-1:0]            delayCount
`endif
);

  localparam int SI = STAGE_IDX_W(NUM_STAGES);
  localparam int SW = SAMPLE_WIDTH;
  localparam int CW = COUNT_WIDTH;

  state_e          state_q, state_d;
  logic [SI-1:0]   stage_q, stage_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            run_q, run_d;
  logic            armed_q, armed_d;
  logic            arm_q;
  logic            arm_rise;
  logic            arm_entry;
  logic            match;
  logic            is_last;
  int              num_last;
  logic [SW-1:0]   cur_mask, cur_value;
  logic [SW-1:0]   cur_rise, cur_fall;
  logic [CW-1:0]   cur_count;
`ifdef TRIG_DELAY_EN
  logic [CW-1:0]   dcnt_q, dcnt_d;
  logic [CW:0]     dnext;
`endif

  assign arm_rise = bus.arm && !arm_q;

  always_comb begin
    cur_mask  = stageMask[int'(stage_q)*SW +: SW];
    cur_value = stageValue[int'(stage_q)*SW +: SW];
    cur_rise  = stageRise[int'(stage_q)*SW +: SW];
    cur_fall  = stageFall[int'(stage_q)*SW +: SW];
    cur_count = stageCount[int'(stage_q)*CW +: CW];
  end

  // out-of-range stage counts select every stage
  always_comb begin
    if (numStages == '0 || int'(numStages) > NUM_STAGES)
      num_last = NUM_STAGES - 1;
    else
      num_last = int'(numStages) - 1;
    is_last = int'(stage_q) >= num_last;
  end

  trigger_stage_match #(
    .SAMPLE_WIDTH(SW)
  ) u_match (
    .clock (clock),
    .reset (reset),
    .valid (bus.valid),
    .clear (arm_entry),
    .dataIn(bus.dataIn),
    .mask  (cur_mask),
    .value (cur_value),
    .rise  (cur_rise),
    .fall  (cur_fall),
    .match (match)
  );

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    cnt_d     = cnt_q;
    arm_entry = 1'b0;
`ifdef TRIG_DELAY_EN
    dcnt_d    = dcnt_q;
    dnext     = {1'b0, dcnt_q} + (CW+1)'(1);
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (arm_rise) begin
          state_d   = ARMED;
          stage_d   = '0;
          cnt_d     = '0;
          arm_entry = 1'b1;
        end
      end
      ARMED: begin
        if (match) begin
          if (cnt_q >= cur_count) begin
            cnt_d = '0;
            if (is_last) begin
`ifdef TRIG_DELAY_EN
              dcnt_d  = '0;
              state_d = (delayCount == '0) ? FIRED : DELAY;
`else
              state_d = FIRED;
`endif
            end else begin
              stage_d = stage_q + SI'(1);
            end
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`ifdef TRIG_DELAY_EN
      DELAY: begin
        if (bus.valid) begin
          if (dnext >= {1'b0, delayCount})
            state_d = FIRED;
          else
            dcnt_d = dcnt_q + CW'(1);
        end
      end
`endif
      FIRED: state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (bus.abort) begin
      state_d   = IDLE;
      stage_d   = '0;
      cnt_d     = '0;
      arm_entry = 1'b0;
    end
    run_d   = (state_d == FIRED);
    armed_d = (state_d == ARMED);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      stage_q <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      armed_q <= 1'b0;
      arm_q   <= 1'b1;
`ifdef TRIG_DELAY_EN
      dcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      armed_q <= armed_d;
      arm_q   <= bus.arm;
`ifdef TRIG_DELAY_EN
      dcnt_q  <= dcnt_d;
`endif
    end
  end

  assign bus.run   = run_q;
  assign bus.armed = armed_q;
  assign bus.stage = stage_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed testbench for trigger_sequencer (default and TRIG_DELAY_EN).
module tb_trigger_sequencer;

  logic        clock;
  logic        reset;
  logic [31:0] stageMask;
  logic [31:0] stageValue;
  logic [31:0] stageRise;
  logic [31:0] stageFall;
  logic [63:0] stageCount;
  logic [2:0]  numStages;
`ifdef TRIG_DELAY_EN
  logic [15:0] delayCount;
`endif
  int tests;
  int fails;

  trigger_sequencer_if #(.SAMPLE_WIDTH(8), .NUM_STAGES(4)) bus ();

  trigger_sequencer #(
    .SAMPLE_WIDTH(8),
    .NUM_STAGES  (4),
    .COUNT_WIDTH (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .stageMask (stageMask),
    .stageValue(stageValue),
    .stageRise (stageRise),
    .stageFall (stageFall),
    .stageCount(stageCount),
    .numStages (numStages)
`ifdef TRIG_DELAY_EN
    ,
    .delayCount(delayCount)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: run=%0d expected finish", 0);
    $fatal(1, "watchdog");
  end

  task automatic cyc(input logic v, input logic [7:0] d,
                     input logic a = 1'b0, input logic ab = 1'b0);
    @(negedge clock);
    bus.valid  = v;
    bus.dataIn = d;
    bus.arm    = a;
    bus.abort  = ab;
    @(posedge clock);
    #1;
  endtask

  task automatic do_arm();
    cyc(1'b0, 8'h00, 1'b1);
  endtask

  task automatic cfg_clear();
    stageMask  = '0;
    stageValue = '0;
    stageRise  = '0;
    stageFall  = '0;
    stageCount = '0;
    numStages  = 3'd1;
  endtask

  task automatic set_stage(input int i, input logic [7:0] m,
                           input logic [7:0] v, input logic [7:0] r,
                           input logic [7:0] f, input logic [15:0] c);
    stageMask[i*8 +: 8]   = m;
    stageValue[i*8 +: 8]  = v;
    stageRise[i*8 +: 8]   = r;
    stageFall[i*8 +: 8]   = f;
    stageCount[i*16 +: 16] = c;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    bus.valid  = 1'b0;
    bus.arm    = 1'b1;
    bus.abort  = 1'b0;
    bus.dataIn = 8'h00;
    cfg_clear();
`ifdef TRIG_DELAY_EN
    delayCount = '0;
`endif
    repeat (2) @(posedge clock);
    #1;
    tests++;
    if (bus.run !== 1'b0) begin
      fails++; $display("FAIL reset_run got %b want 0", bus.run);
    end
    tests++;
    if (bus.armed !== 1'b0) begin
      fails++; $display("FAIL reset_armed got %b want 0", bus.armed);
    end
    tests++;
    if (bus.stage !== 2'd0) begin
      fails++; $display("FAIL reset_stage got %0d want 0", bus.stage);
    end
    @(negedge clock);
    reset = 1'b0;
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    tests++;
    if (bus.armed !== 1'b0) begin
      fails++; $display("FAIL arm_held_reset got %b want 0", bus.armed);
    end
    cyc(1'b0, 8'h00);
  endtask

  task automatic test_single_rise();
    cfg_clear();
    set_stage(0, 8'h00, 8'h00, 8'h01, 8'h00, 16'd0);
    do_arm();
    tests++;
    if (bus.armed !== 1'b1) begin
      fails++; $display("FAIL single_armed got %b want 1", bus.armed);
    end
    cyc(1'b1, 8'h00);
    tests++;
    if (bus.run !== 1'b0) begin
      fails++; $display("FAIL single_pre got %b want 0", bus.run);
    end
    cyc(1'b1, 8'h01);
    tests++;
    if (bus.run !== 1'b1 || bus.stage !== 2'd0 || bus.armed !== 1'b0) begin
      fails++;
      $display("FAIL single_fire run=%b stage=%0d armed=%b want 1 0 0",
               bus.run, bus.stage, bus.armed);
    end
    cyc(1'b0, 8'h01);
    tests++;
    if (bus.run !== 1'b0 || bus.armed !== 1'b0) begin
      fails++;
      $display("FAIL single_done run=%b armed=%b want 0 0",
               bus.run, bus.armed);
    end
  endtask

  task automatic test_first_sample();
    cyc(1'b1, 8'h00);
    do_arm();
    cyc(1'b1, 8'h01);
    tests++;
    if (bus.run !== 1'b0 || bus.armed !== 1'b1) begin
      fails++;
      $display("FAIL first_sample run=%b armed=%b want 0 1",
               bus.run, bus.armed);
    end
    cyc(1'b1, 8'h00);
    cyc(1'b1, 8'h01);
    tests++;
    if (bus.run !== 1'b1) begin
      fails++; $display("FAIL first_then_rise got %b want 1", bus.run);
    end
    cyc(1'b0, 8'h00);
  endtask

  task automatic test_two_stage();
    cfg_clear();
    numStages = 3'd2;
    set_stage(0, 8'hFF, 8'hA5, 8'h00, 8'h00, 16'd0);
    set_stage(1, 8'h00, 8'h00, 8'h00, 8'h80, 16'd2);
    do_arm();
    cyc(1'b1, 8'h00);
    tests++;
    if (bus.stage !== 2'd0) begin
      fails++; $display("FAIL two_s0 got %0d want 0", bus.stage);
    end
    cyc(1'b1, 8'hA5);
    tests++;
    if (bus.stage !== 2'd1 || bus.run !== 1'b0) begin
      fails++;
      $display("FAIL two_adv stage=%0d run=%b want 1 0",
               bus.stage, bus.run);
    end
    cyc(1'b1, 8'h00);
    cyc(1'b1, 8'h80);
    cyc(1'b1, 8'h00);
    cyc(1'b1, 8'h80);
    tests++;
    if (bus.run !== 1'b0 || bus.stage !== 2'd1) begin
      fails++;
      $display("FAIL two_mid run=%b stage=%0d want 0 1",
               bus.run, bus.stage);
    end
    cyc(1'b1, 8'h00);
    tests++;
    if (bus.run !== 1'b1) begin
      fails++; $display("FAIL two_fire got %b want 1", bus.run);
    end
    cyc(1'b0, 8'h00);
  endtask

  task automatic test_valid_gap();
    cfg_clear();
    set_stage(0, 8'h00, 8'h00, 8'h01, 8'h00, 16'd1);
    do_arm();
    cyc(1'b1, 8'h01);
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h01);
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h01);
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h01);
    cyc(1'b1, 8'h00);
    cyc(1'b1, 8'h01);
    tests++;
    if (bus.run !== 1'b0 || bus.armed !== 1'b1) begin
      fails++;
      $display("FAIL gap_hist run=%b armed=%b want 0 1",
               bus.run, bus.armed);
    end
    cyc(1'b1, 8'h00);
    cyc(1'b0, 8'h01);
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h01);
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h00);
    tests++;
    if (bus.run !== 1'b0) begin
      fails++; $display("FAIL gap_invalid got %b want 0", bus.run);
    end
    cyc(1'b1, 8'h01);
    tests++;
    if (bus.run !== 1'b1) begin
      fails++; $display("FAIL gap_fire got %b want 1", bus.run);
    end
    cyc(1'b0, 8'h00);
  endtask

  task automatic test_abort();
    cfg_clear();
    set_stage(0, 8'h01, 8'h01, 8'h00, 8'h00, 16'd0);
    do_arm();
    cyc(1'b1, 8'h01, 1'b0, 1'b1);
    tests++;
    if (bus.run !== 1'b0 || bus.armed !== 1'b0 || bus.stage !== 2'd0) begin
      fails++;
      $display("FAIL abort_final run=%b armed=%b stage=%0d want 0 0 0",
               bus.run, bus.armed, bus.stage);
    end
    cyc(1'b0, 8'h00);
    tests++;
    if (bus.run !== 1'b0) begin
      fails++; $display("FAIL abort_after got %b want 0", bus.run);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    tests++;
    if (bus.armed !== 1'b0) begin
      fails++; $display("FAIL abort_vs_arm got %b want 0", bus.armed);
    end
    cyc(1'b0, 8'h00);
    do_arm();
    cyc(1'b1, 8'h01);
    tests++;
    if (bus.run !== 1'b1) begin
      fails++; $display("FAIL abort_rearm got %b want 1", bus.run);
    end
    cyc(1'b0, 8'h00);
  endtask

  task automatic test_reset_mid();
    cfg_clear();
    numStages = 3'd2;
    set_stage(0, 8'hFF, 8'hA5, 8'h00, 8'h00, 16'd0);
    set_stage(1, 8'h00, 8'h00, 8'h00, 8'h80, 16'd0);
    do_arm();
    cyc(1'b1, 8'hA5);
    tests++;
    if (bus.stage !== 2'd1) begin
      fails++; $display("FAIL rmid_stage got %0d want 1", bus.stage);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (bus.run !== 1'b0 || bus.armed !== 1'b0 || bus.stage !== 2'd0) begin
      fails++;
      $display("FAIL rmid_async run=%b armed=%b stage=%0d want 0 0 0",
               bus.run, bus.armed, bus.stage);
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    cyc(1'b1, 8'h00);
    tests++;
    if (bus.run !== 1'b0 || bus.armed !== 1'b0) begin
      fails++;
      $display("FAIL rmid_after run=%b armed=%b want 0 0",
               bus.run, bus.armed);
    end
  endtask

  task automatic test_num_stages();
    cfg_clear();
    numStages = 3'd0;
    do_arm();
    cyc(1'b1, 8'h00);
    cyc(1'b1, 8'h00);
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h00);
    tests++;
    if (bus.stage !== 2'd3 || bus.run !== 1'b0) begin
      fails++;
      $display("FAIL nst0_mid stage=%0d run=%b want 3 0",
               bus.stage, bus.run);
    end
    cyc(1'b1, 8'h00);
    tests++;
    if (bus.run !== 1'b1) begin
      fails++; $display("FAIL nst0_fire got %b want 1", bus.run);
    end
    cyc(1'b0, 8'h00);
    numStages = 3'd7;
    do_arm();
    repeat (3) cyc(1'b1, 8'h00);
    tests++;
    if (bus.run !== 1'b0) begin
      fails++; $display("FAIL nst7_mid got %b want 0", bus.run);
    end
    cyc(1'b1, 8'h00);
    tests++;
    if (bus.run !== 1'b1) begin
      fails++; $display("FAIL nst7_fire got %b want 1", bus.run);
    end
    cyc(1'b0, 8'h00);
    numStages = 3'd1;
    set_stage(0, 8'h00, 8'h00, 8'h00, 8'h00, 16'd2);
    do_arm();
    cyc(1'b1, 8'h00);
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h00);
    tests++;
    if (bus.run !== 1'b0) begin
      fails++; $display("FAIL count_mid got %b want 0", bus.run);
    end
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h00);
    tests++;
    if (bus.run !== 1'b1) begin
      fails++; $display("FAIL count_fire got %b want 1", bus.run);
    end
    cyc(1'b0, 8'h00);
  endtask

`ifdef TRIG_DELAY_EN
  task automatic test_delay();
    cfg_clear();
    delayCount = 16'd3;
    do_arm();
    cyc(1'b1, 8'h00);
    cyc(1'b1, 8'h00);
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h00);
    tests++;
    if (bus.run !== 1'b0) begin
      fails++; $display("FAIL delay_mid got %b want 0", bus.run);
    end
    cyc(1'b1, 8'h00);
    tests++;
    if (bus.run !== 1'b1) begin
      fails++; $display("FAIL delay_fire got %b want 1", bus.run);
    end
    cyc(1'b0, 8'h00);
    delayCount = 16'd0;
    do_arm();
    cyc(1'b1, 8'h00);
    tests++;
    if (bus.run !== 1'b1) begin
      fails++; $display("FAIL delay0_fire got %b want 1", bus.run);
    end
    cyc(1'b0, 8'h00);
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single_rise();
    test_first_sample();
    test_two_stage();
    test_valid_gap();
    test_abort();
    test_reset_mid();
    test_num_stages();
`ifdef TRIG_DELAY_EN
    test_delay();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
